// File: rtl/mac_accumulator.sv
// Saturating signed multiply-accumulate back end: sums up to N_TERMS products
// per block, then presents the block result over a valid/ready handshake.
module mac_accumulator #(
  parameter int WIDTH   = 64,
  parameter int N_TERMS = 8,
  parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] prod_in,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] acc_out,
  output logic [CNT_W-1:0] count_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             state_dbg
);

  // Handshake: a term transfers on an edge where in_valid & in_ready are high,
  // a result on an edge where out_valid & out_ready are high. in_ready and
  // out_valid come from the state register only.
  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] acc_q, acc_next;
  logic [CNT_W-1:0] count_q, count_next;
  logic             ovf_q, ovf_next;
  logic [WIDTH:0]   sum;
  logic             sat_event;
  logic [WIDTH-1:0] sat_sum;

  // One guard bit is enough: disagreement with the sign bit means overflow.
  always_comb begin
    sum       = {acc_q[WIDTH-1], acc_q} + {prod_in[WIDTH-1], prod_in};
    sat_event = sum[WIDTH] ^ sum[WIDTH-1];
    if (!sat_event)
      sat_sum = sum[WIDTH-1:0];
    else if (sum[WIDTH])
      sat_sum = MIN_NEG;
    else
      sat_sum = MAX_POS;
  end

  always_comb begin
    state_next = state;
    acc_next   = acc_q;
    count_next = count_q;
    ovf_next   = ovf_q;
    case (state)
      ACC: begin
        if (in_valid) begin
          acc_next   = sat_sum;
          count_next = count_q + CNT_W'(1);
          ovf_next   = ovf_q | sat_event;
          if (in_last || (count_q == LAST_CNT))
            state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_next   = '0;
          count_next = '0;
          ovf_next   = 1'b0;
          state_next = ACC;
        end
      end
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACC;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_next;
      acc_q   <= acc_next;
      count_q <= count_next;
      ovf_q   <= ovf_next;
    end
  end

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);
  assign acc_out   = acc_q;
  assign count_out = count_q;
  assign ovf       = ovf_q;
  assign state_dbg = state;

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Signed multiply-accumulate back end that sits directly downstream of the 32x32 signed `Multiplier`. It consumes the 64-bit product stream (`result`) one term per cycle and sums up to `N_TERMS` terms into a saturating 64-bit accumulator. It then presents the finished dot-product with a valid/ready handshake, and clears itself for the next block once the result is taken.

## Interface
- `WIDTH`, 64, product and accumulator width (two's complement).
- `N_TERMS`, 8, maximum terms per block; must be ≥ 1.
- `CNT_W`, `$clog2(N_TERMS+1)`, width of term counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `prod_in`  in  WIDTH  signed product, driven from `Multiplier.result`.
- `in_valid`  in  1  `prod_in` is valid this cycle.
- `in_last`  in  1  qualifies `in_valid`; this term closes the block early.
- `in_ready`  out  1  block accepts a term this cycle.
- `acc_out`  out  WIDTH  accumulator register, signed.
- `count_out`  out  CNT_W  number of terms accumulated in current block.
- `ovf`  out  1  sticky; at least one saturation occurred in current block.
- `out_valid`  out  1  `acc_out`/`count_out`/`ovf` hold a finished block.
- `out_ready`  in  1  consumer takes the finished block.

## Operation
- Two states: ACC (collecting) and HOLD (result presented). Reset state is ACC.
- `in_ready` = (state == ACC). `out_valid` = (state == HOLD). Both derive from the state register only, with no combinational path from `in_valid` or `out_ready`.
- ACC, accept (`in_valid & in_ready`):
  - `acc <= sat(acc + prod_in)`.
  - `count <= count + 1`.
  - `ovf <= ovf | sat_event`.
  - If `in_last` is set or `count + 1 == N_TERMS`, go to HOLD.
- ACC, no accept: all registers hold.
- HOLD:
  - Inputs are ignored. `in_valid` is dropped and is not queued.
  - `acc_out`, `count_out` and `ovf` stay stable.
  - On `out_ready`: `acc <= 0`, `count <= 0`, `ovf <= 0`, go to ACC.
- Arithmetic: the sum is formed at WIDTH+1 bits with both operands sign-extended. If sum[WIDTH] ≠ sum[WIDTH-1], the result saturates: positive overflow gives 0x7FFF_FFFF_FFFF_FFFF, negative overflow gives 0x8000_0000_0000_0000. Later terms add from the saturated value; there is no wrap-around.
- `count_out` never exceeds `N_TERMS`. `in_last` with `N_TERMS == 1` behaves the same as without it.
- An empty block is impossible: HOLD is entered only on an accepted term.

## Timing
- Reset (`rst` high at an edge) forces: state ACC, `acc_out` 0, `count_out` 0, `ovf` 0, `out_valid` 0.
- `in_ready` reads 1 in the first cycle after reset deasserts.
- `rst` overrides everything, including mid-block or in HOLD. A partial sum is discarded, and a term presented in the same cycle as `rst` is not accepted.
- Accumulate latency is 1 cycle: `acc_out` reflects a term on the edge after it is accepted.
- `out_valid` rises on the edge after the final accept, and the final sum is visible in that same cycle.
- Result handoff:
  - The result is transferred on the edge where `out_valid & out_ready` are both high.
  - The next cycle shows `out_valid` 0, `in_ready` 1 and a cleared accumulator.
  - Minimum HOLD duration is 1 cycle, so sustained throughput is N_TERMS terms per N_TERMS+1 cycles.
- `out_ready` in ACC has no effect.
- `in_valid` may toggle freely in ACC; bubbles do not disturb the accumulator.

## Test plan
- Reset, then 4 products with `N_TERMS=4`, back-to-back, `in_last` on the 4th, `out_ready` 1.
  - Products: 50·(−40)=−2000, 90·70=6300, (−80)·(−65)=5200, (−10)·325=−3250.
  - Required: `out_valid` one cycle after the 4th accept, `acc_out`=0x0000_0000_0000_186A (6250), `count_out`=4, `ovf`=0.
  - Required: `in_ready` returns to 1 the next cycle with `acc_out`=0.
- Early close: −500·2000 then −999·999 with `in_last` on the 2nd.
  - Required: `acc_out`=0xFFFF_FFFF_FFE1_834F (−1998001), `count_out`=2.
- Saturation: 0x7FFF_FFFF_FFFF_FFF0 + 0x20, then + (−0x10).
  - Required after the 1st term: `acc_out`=0x7FFF_FFFF_FFFF_FFFF, `ovf`=1.
  - Required after the 2nd term: `acc_out`=0x7FFF_FFFF_FFFF_FFEF, `ovf` still 1.
  - Required: `ovf` clears after handoff.
  - Repeat with negatives and check the floor 0x8000_0000_0000_0000.
- Backpressure: finish a block, then hold `out_ready` 0 for 5 cycles while driving `in_valid` 1 with junk.
  - Required: `in_ready`=0 throughout, and `acc_out`/`count_out` stable.
  - Required: the junk term is never accumulated, and the next block starts from 0.
- Reset mid-block: accept 3 terms, assert `rst` for 1 cycle with `in_valid` 1.
  - Required: all outputs return to reset values, that term is not counted, and the following block sums only post-reset terms.
- Full-length and bubbles: 8 terms of +1 with `N_TERMS=8` and random `in_valid` gaps.
  - Required: `out_valid` after exactly 8 accepts, `acc_out`=8, `count_out`=8.
